// File: rtl/sdram_traffic_gen_if.sv
// Avalon-MM burst master bus between the traffic generator and the SDRAM controller slave port.
// Pure wiring, no latency of its own.
// Backpressure is the slave's m_waitrequest stall; read returns are flagged by m_readdatavalid.
interface sdram_traffic_gen_if;
  logic        m_read;
  logic        m_write;
  logic [21:0] m_address;
  logic [15:0] m_writedata;
  logic [8:0]  m_burstcount;
  logic [1:0]  m_byteenable;
  logic        m_waitrequest;
  logic        m_readdatavalid;
  logic [15:0] m_readdata;

  modport master (
    output m_read, m_write, m_address, m_writedata, m_burstcount, m_byteenable,
    input  m_waitrequest, m_readdatavalid, m_readdata
  );

  modport slave (
    input  m_read, m_write, m_address, m_writedata, m_burstcount, m_byteenable,
    output m_waitrequest, m_readdatavalid, m_readdata
  );
endinterface

// File: rtl/sdram_traffic_gen.sv
// SDRAM traffic generator: writes an address-derived pattern over a region, reads it back, counts mismatches.
// Latency: first m_write 1 cycle after start; done 2 cycles after the last read beat; all outputs registered.
// Backpressure: requests, address and write data are held stable while m_waitrequest is high; stalls are bounded by TIMEOUT.
module sdram_traffic_gen #(
  parameter int          BURST      = 8,
  parameter int          NUM_BURSTS = 16,
  parameter logic [21:0] BASE_ADDR  = 22'h000000,
  parameter logic [15:0] PATTERN    = 16'hA5A5,
  parameter int          TIMEOUT    = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  sdram_traffic_gen_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [15:0]                err_count,
  output logic [21:0]                first_err_addr
);

  localparam int KW = 9;
  localparam int BW = $clog2(NUM_BURSTS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [KW-1:0] LAST_BEAT  = KW'(BURST - 1);
  localparam logic [BW-1:0] LAST_BURST = BW'(NUM_BURSTS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [8:0]    BURST_CNT  = 9'(BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_GAP,
    S_RD_REQ,
    S_RD_DATA,
    S_RD_GAP,
    S_FINISH
  } state_t;

  // Data pattern is a pure function of the beat's word address.
  function automatic logic [15:0] pat(input logic [21:0] a);
    return a[15:0] ^ {10'b0, a[21:16]} ^ PATTERN;
  endfunction

  state_t          state_q,    state_d;
  logic [BW-1:0]   b_q,        b_d;
  logic [KW-1:0]   k_q,        k_d;
  logic [TW-1:0]   tmo_q,      tmo_d;
  logic            rd_q,       rd_d;
  logic            wr_q,       wr_d;
  logic [21:0]     addr_q,     addr_d;
  logic [15:0]     wdata_q,    wdata_d;
  logic [21:0]     exp_addr_q, exp_addr_d;
  logic            cmp_err_q,  cmp_err_d;
  logic [21:0]     cmp_addr_q, cmp_addr_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;
  logic            pass_q,     pass_d;
  logic            timeout_q,  timeout_d;
  logic [15:0]     err_q,      err_d;
  logic [21:0]     ferr_q,     ferr_d;

  // Next-state, request generation, read-compare pipeline and status accumulation.
  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    k_d        = k_q;
    tmo_d      = '0;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    exp_addr_d = exp_addr_q;
    cmp_err_d  = 1'b0;
    cmp_addr_d = cmp_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    ferr_d     = ferr_q;

    // Second stage of the compare: fold last cycle's mismatch into the counters.
    if (cmp_err_q) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'h0000) ferr_d = cmp_addr_q;
    end

    case (state_q)
      S_IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (start) begin
          err_d     = '0;
          ferr_d    = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          b_d       = '0;
          k_d       = '0;
          wr_d      = 1'b1;
          addr_d    = BASE_ADDR;
          wdata_d   = pat(BASE_ADDR);
          state_d   = S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        if (!bus.m_waitrequest) begin
          if (k_q == LAST_BEAT) begin
            // Burst complete: m_write must drop so the slave closes the burst.
            wr_d    = 1'b0;
            k_d     = '0;
            state_d = S_WR_GAP;
          end else begin
            k_d     = k_q + KW'(1);
            addr_d  = addr_q + 22'd1;
            wdata_d = pat(addr_q + 22'd1);
          end
        end else if (tmo_q == TMO_LAST) begin
          wr_d      = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_WR_GAP: begin
        if (b_q == LAST_BURST) begin
          b_d     = '0;
          rd_d    = 1'b1;
          addr_d  = BASE_ADDR;
          state_d = S_RD_REQ;
        end else begin
          b_d     = b_q + BW'(1);
          wr_d    = 1'b1;
          addr_d  = addr_q + 22'd1;
          wdata_d = pat(addr_q + 22'd1);
          state_d = S_WR_REQ;
        end
      end

      S_RD_REQ: begin
        if (!bus.m_waitrequest) begin
          rd_d       = 1'b0;
          exp_addr_d = addr_q;
          k_d        = '0;
          state_d    = S_RD_DATA;
        end else if (tmo_q == TMO_LAST) begin
          rd_d      = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_RD_DATA: begin
        if (bus.m_readdatavalid) begin
          cmp_err_d  = (bus.m_readdata != pat(exp_addr_q));
          cmp_addr_d = exp_addr_q;
          exp_addr_d = exp_addr_q + 22'd1;
          if (k_q == LAST_BEAT) begin
            k_d = '0;
            if (b_q == LAST_BURST) begin
              state_d = S_FINISH;
            end else begin
              b_d     = b_q + BW'(1);
              state_d = S_RD_GAP;
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_RD_GAP: begin
        // exp_addr_q has advanced by exactly one burst, so it is the next burst start.
        rd_d    = 1'b1;
        addr_d  = exp_addr_q;
        state_d = S_RD_REQ;
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_d == 16'h0000) && !timeout_q;
        state_d = S_IDLE;
      end

      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops requests immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      b_q        <= '0;
      k_q        <= '0;
      tmo_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      exp_addr_q <= '0;
      cmp_err_q  <= 1'b0;
      cmp_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      ferr_q     <= '0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      k_q        <= k_d;
      tmo_q      <= tmo_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      exp_addr_q <= exp_addr_d;
      cmp_err_q  <= cmp_err_d;
      cmp_addr_q <= cmp_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.m_read       = rd_q;
  assign bus.m_write      = wr_q;
  assign bus.m_address    = addr_q;
  assign bus.m_writedata  = wdata_q;
  assign bus.m_burstcount = BURST_CNT;
  assign bus.m_byteenable = 2'b11;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Bench for sdram_traffic_gen: slave model, flat write/read address model and status expectations.
// Two instances: a base-0 region and a region that wraps past the top of the address space.
// All sampling and input driving happen on the falling clock edge.
module tb_sdram_traffic_gen;

  localparam int          B0 = 8, N0 = 4;
  localparam logic [21:0] A0 = 22'h000000;
  localparam int          B1 = 4, N1 = 2;
  localparam logic [21:0] A1 = 22'h3FFFFC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_s [2];
  logic        i_wait  [2];
  logic        i_rvalid[2];
  logic [15:0] i_rdata [2];
  logic        o_rd    [2];
  logic        o_wr    [2];
  logic [21:0] o_addr  [2];
  logic [15:0] o_wdata [2];
  logic [8:0]  o_bc    [2];
  logic [1:0]  o_be    [2];
  logic        s_busy  [2];
  logic        s_done  [2];
  logic        s_pass  [2];
  logic        s_tmo   [2];
  logic [15:0] s_err   [2];
  logic [21:0] s_ferr  [2];

  sdram_traffic_gen_if bus0();
  sdram_traffic_gen_if bus1();

  assign bus0.m_waitrequest   = i_wait[0];
  assign bus0.m_readdatavalid = i_rvalid[0];
  assign bus0.m_readdata      = i_rdata[0];
  assign bus1.m_waitrequest   = i_wait[1];
  assign bus1.m_readdatavalid = i_rvalid[1];
  assign bus1.m_readdata      = i_rdata[1];
  assign o_rd[0] = bus0.m_read;   assign o_rd[1] = bus1.m_read;
  assign o_wr[0] = bus0.m_write;  assign o_wr[1] = bus1.m_write;
  assign o_addr[0] = bus0.m_address;     assign o_addr[1] = bus1.m_address;
  assign o_wdata[0] = bus0.m_writedata;  assign o_wdata[1] = bus1.m_writedata;
  assign o_bc[0] = bus0.m_burstcount;    assign o_bc[1] = bus1.m_burstcount;
  assign o_be[0] = bus0.m_byteenable;    assign o_be[1] = bus1.m_byteenable;

  sdram_traffic_gen #(.BURST(B0), .NUM_BURSTS(N0), .BASE_ADDR(A0), .PATTERN(16'hA5A5), .TIMEOUT(64)) dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .bus(bus0.master),
    .busy(s_busy[0]), .done(s_done[0]), .pass(s_pass[0]), .timeout(s_tmo[0]),
    .err_count(s_err[0]), .first_err_addr(s_ferr[0])
  );

  sdram_traffic_gen #(.BURST(B1), .NUM_BURSTS(N1), .BASE_ADDR(A1), .PATTERN(16'hA5A5), .TIMEOUT(64)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .bus(bus1.master),
    .busy(s_busy[1]), .done(s_done[1]), .pass(s_pass[1]), .timeout(s_tmo[1]),
    .err_count(s_err[1]), .first_err_addr(s_ferr[1])
  );

  int errors = 0;
  int checks = 0;

  // Model state for the instance under test.
  int          cur;
  int          nbeats, wr_idx, rd_burst, beats_seen, exp_err, last_cyc, cyc, done_cyc;
  logic [21:0] exp_ferr;
  bit          done_seen, stall_mode, stuck_mode, no_rvalid, gap_chk, need_pick, start_req;
  int          stall_left, rdelay;
  int          rq[$];
  logic [15:0] mem [int];
  int          wcnt[int];

  function automatic int cfg_burst(input int g); return (g == 0) ? B0 : B1; endfunction
  function automatic int cfg_nb(input int g);    return (g == 0) ? N0 : N1; endfunction
  function automatic logic [21:0] cfg_base(input int g); return (g == 0) ? A0 : A1; endfunction

  function automatic logic [21:0] maddr(input int g, input int i);
    logic [21:0] off;
    off = 22'(i);
    return cfg_base(g) + off;
  endfunction

  function automatic logic [15:0] mpat(input logic [21:0] a);
    return a[15:0] ^ {10'b0, a[21:16]} ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One bus cycle: compare outputs against the model, then drive the slave response.
  task automatic cycle();
    int          bb;
    logic [21:0] a;
    logic [15:0] d;
    bb = cfg_burst(cur);
    @(negedge clk);
    cyc++;
    start_s[cur] = start_req;
    start_req    = 1'b0;
    i_wait[cur]   = 1'b0;
    i_rvalid[cur] = 1'b0;
    i_rdata[cur]  = 16'h0000;

    if (gap_chk) begin
      chk("wr_gap_low", o_wr[cur], 0);
      gap_chk = 1'b0;
    end
    if (s_done[cur]) begin
      chk("done_once", done_seen, 0);
      done_seen = 1'b1;
      done_cyc  = cyc;
    end

    if (o_wr[cur]) begin
      a = maddr(cur, wr_idx);
      chk("wr_in_range", wr_idx < nbeats, 1);
      chk("wr_addr", o_addr[cur], a);
      chk("wr_data", o_wdata[cur], mpat(a));
    end
    if (o_rd[cur]) begin
      chk("rd_addr", o_addr[cur], maddr(cur, rd_burst * bb));
    end

    if (o_wr[cur] || o_rd[cur]) begin
      chk("one_req", o_wr[cur] & o_rd[cur], 0);
      chk("burstcount", o_bc[cur], bb);
      chk("byteenable", o_be[cur], 3);
      if (need_pick) begin
        stall_left = stall_mode ? int'($urandom_range(0, 20)) : 0;
        need_pick  = 1'b0;
      end
      if (stall_left > 0) begin
        i_wait[cur] = 1'b1;
        stall_left--;
      end else begin
        need_pick = 1'b1;
        if (o_wr[cur]) begin
          a = maddr(cur, wr_idx);
          if (wr_idx == 0) chk("first_beat_lit", o_wdata[cur], (cur == 0) ? 16'hA5A5 : 16'h5A66);
          if (cur == 0 && wr_idx == 31) chk("last_beat_lit", o_wdata[cur], 16'hA5BA);
          chk("wr_once", wcnt.exists(int'(a)), 0);
          wcnt[int'(a)] = 1;
          mem[int'(a)]  = o_wdata[cur];
          wr_idx++;
          if (wr_idx % bb == 0) gap_chk = 1'b1;
        end else begin
          a = maddr(cur, rd_burst * bb);
          chk("rd_after_writes", wr_idx, nbeats);
          if (cur == 1 && rd_burst == 1) chk("wrap_addr_lit", o_addr[cur], 0);
          for (int k = 0; k < bb; k++) rq.push_back(int'(a + 22'(k)));
          rd_burst++;
          rdelay = 2;
        end
      end
    end

    if (rq.size() > 0 && !no_rvalid) begin
      if (rdelay > 0) begin
        rdelay--;
      end else if (!stall_mode || $urandom_range(0, 3) != 0) begin
        a = 22'(rq.pop_front());
        d = mem.exists(int'(a)) ? mem[int'(a)] : 16'h0000;
        if (stuck_mode && a == 22'd5) d = d | 16'h0008;
        i_rvalid[cur] = 1'b1;
        i_rdata[cur]  = d;
        beats_seen++;
        if (d != mpat(a)) begin
          exp_err++;
          if (exp_err == 1) exp_ferr = a;
        end
        if (beats_seen == nbeats) last_cyc = cyc;
      end
    end
  endtask

  task automatic model_clear(input int g);
    cur = g;
    nbeats = cfg_burst(g) * cfg_nb(g);
    wr_idx = 0; rd_burst = 0; beats_seen = 0; exp_err = 0; exp_ferr = '0;
    last_cyc = 0; done_cyc = 0; done_seen = 1'b0; gap_chk = 1'b0;
    need_pick = 1'b1; stall_left = 0; rdelay = 0;
    rq.delete(); mem.delete(); wcnt.delete();
  endtask

  task automatic run_test(input int g, input bit st, input bit sk, input bit nr, input bit dbl);
    bit exp_pass;
    model_clear(g);
    stall_mode = st; stuck_mode = sk; no_rvalid = nr;
    start_req = 1'b1;
    cycle();
    cycle();
    chk("start_to_write", o_wr[g], 1);
    chk("busy_set", s_busy[g], 1);
    chk("pass_cleared", s_pass[g], 0);
    chk("tmo_cleared", s_tmo[g], 0);
    for (int n = 0; n < 4000 && !done_seen; n++) begin
      if (dbl && n == 15) start_req = 1'b1;
      cycle();
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_wait: actual=no done required=done within budget");
    end else begin
      exp_pass = (exp_err == 0) && !nr;
      chk("err_count", s_err[g], exp_err);
      chk("first_err_addr", s_ferr[g], exp_ferr);
      chk("pass", s_pass[g], exp_pass);
      chk("timeout", s_tmo[g], nr);
      chk("busy_clear", s_busy[g], 0);
      chk("reqs_low_at_done", o_wr[g] | o_rd[g], 0);
      if (sk) begin
        chk("stuck_err_lit", s_err[g], 1);
        chk("stuck_addr_lit", s_ferr[g], 22'h000005);
      end
      if (!nr) begin
        chk("done_latency", done_cyc - last_cyc, 2);
        chk("writes_total", wr_idx, nbeats);
        chk("beats_total", beats_seen, nbeats);
      end
      cycle();
      chk("done_pulse_1cyc", s_done[g], 0);
      chk("pass_sticky", s_pass[g], exp_pass);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0; i_wait[g] = 1'b0; i_rvalid[g] = 1'b0; i_rdata[g] = 16'h0000;
    end
    cyc = 0; start_req = 1'b0; stall_mode = 1'b0; stuck_mode = 1'b0; no_rvalid = 1'b0;
    model_clear(0);

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_m_read", o_rd[0], 0);
    chk("rst_m_write", o_wr[0], 0);
    chk("rst_m_address", o_addr[0], 0);
    chk("rst_m_writedata", o_wdata[0], 0);
    chk("rst_burstcount0", o_bc[0], 8);
    chk("rst_burstcount1", o_bc[1], 4);
    chk("rst_byteenable", o_be[0], 3);
    chk("rst_busy", s_busy[0], 0);
    chk("rst_done", s_done[0], 0);
    chk("rst_pass", s_pass[0], 0);
    chk("rst_timeout", s_tmo[0], 0);
    chk("rst_err_count", s_err[0], 0);
    chk("rst_first_err", s_ferr[0], 0);
    reset = 1'b0;
    cycle();

    // Ideal slave, with a second start pulse while busy.
    run_test(0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Stuck bit 3 at address 5.
    run_test(0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Random wait-state stalls and gaps in read returns.
    run_test(0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Region wrapping past 22'h3FFFFF.
    run_test(1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Slave never returns read data.
    run_test(0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of the write pass.
    model_clear(0);
    stall_mode = 1'b0; stuck_mode = 1'b0; no_rvalid = 1'b0;
    start_req = 1'b1;
    for (int n = 0; n < 200 && wr_idx < 10; n++) cycle();
    chk("mid_write_reached", wr_idx >= 10, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_write", o_wr[0], 0);
    chk("rst_async_read", o_rd[0], 0);
    chk("rst_async_busy", s_busy[0], 0);
    repeat (3) cycle();
    reset = 1'b0;
    rq.delete();
    repeat (5) cycle();
    chk("no_done_after_reset", done_seen, 0);
    chk("idle_after_reset", o_wr[0] | o_rd[0] | s_busy[0], 0);

    // Normal run after the aborted one.
    run_test(0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_traffic_gen.md
# sdram_traffic_gen

Avalon-MM burst master that sits directly upstream of the SDRAM controller's `s_*` slave port in the hardware-test system. On `start` it does two passes over a contiguous region:
- write pass: fills it with an address-derived pattern;
- read pass: reads it back and compares every beat.

It reports pass/fail, an error count and the first failing address to a status interface.

## Interface
- `BURST`, 8: beats per burst; legal values 1, 2, 4, 8, 256.
- `NUM_BURSTS`, 16: bursts per pass, ≥1.
- `BASE_ADDR`, 22'h000000: first word address of the region.
- `PATTERN`, 16'hA5A5: XOR seed for the data pattern.
- `TIMEOUT`, 4096: maximum cycles allowed in one wait state.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-high; all flops return to their reset values immediately.
- `start` in 1: a one-cycle pulse starts a test; it is ignored while `busy`.
- `m_read` out 1: Avalon read request.
- `m_write` out 1: Avalon write request.
- `m_address` out 22: word address.
- `m_writedata` out 16: write data.
- `m_burstcount` out 9: constant `BURST`; it is valid whenever `m_read` or `m_write` is high.
- `m_byteenable` out 2: constant 2'b11.
- `m_waitrequest` in 1: slave stall.
- `m_readdatavalid` in 1: read beat valid.
- `m_readdata` in 16: read data.
- `busy` out 1: high from `start` until `done`.
- `done` out 1: a one-cycle pulse when the test ends.
- `pass` out 1: sticky; 1 when the last test had `err_count` = 0 and no timeout.
- `timeout` out 1: sticky; the last test aborted on timeout.
- `err_count` out 16: number of mismatched beats; saturates at 16'hFFFF.
- `first_err_addr` out 22: address of the first mismatch; 0 if there was none.

## Operation
- **Pattern:** `pat(a)` = `a[15:0] ^ {10'b0, a[21:16]} ^ PATTERN`. It is computed from the 22-bit address of each beat.
- **Address arithmetic:** burst b, beat k has address `BASE_ADDR + b*BURST + k`, computed modulo 2^22. Wrap past 22'h3FFFFF goes to 0 silently.
- **Write beat addressing:** the slave accepts a write beat only when `m_address` equals the burst start plus the beats already taken. Therefore `m_address` advances by 1 per accepted write beat.
- **Read addressing:** reads present the burst start address only.

FSM states:
- **IDLE**
  - All requests are low.
  - On `start`: clear `err_count`, `first_err_addr`, `pass`, `timeout`; set `busy`; b = 0, k = 0; go to WR_REQ.
- **WR_REQ**
  - `m_write` = 1, `m_address` = addr(b,k), `m_writedata` = pat(addr).
  - A beat is accepted when `m_write & !m_waitrequest`; then k++.
  - After beat `BURST-1` is accepted: `m_write` = 0, go to WR_GAP.
- **WR_GAP**
  - Requests stay low for exactly 1 cycle. The slave needs `s_write` low to close the burst.
  - k = 0, b++.
  - If b = `NUM_BURSTS`: b = 0, go to RD_REQ; else go to WR_REQ.
- **RD_REQ**
  - `m_read` = 1, `m_address` = addr(b,0).
  - On `!m_waitrequest`: drop `m_read` next cycle, go to RD_DATA.
- **RD_DATA**
  - For each `m_readdatavalid`, compare `m_readdata` with pat(addr(b,k)), then k++.
  - On mismatch: `err_count` +1 (saturating). If this is the first mismatch, latch `first_err_addr`.
  - After `BURST` beats: k = 0, b++.
  - If b = `NUM_BURSTS`, go to FINISH; else go to RD_REQ after 1 idle cycle.
  - Valid beats arriving outside RD_DATA are ignored.
- **FINISH**
  - `done` = 1 for one cycle; `busy` = 0.
  - `pass` = (`err_count` == 0) & !`timeout`.
  - Go to IDLE.
- **Timeout**
  - A cycle counter runs in WR_REQ, RD_REQ and RD_DATA. It resets on every accepted beat or state change.
  - Reaching `TIMEOUT`: set `timeout`, drop all requests, go to FINISH (`pass` = 0).
- **Reset mid-test:** requests drop asynchronously and the FSM returns to IDLE. No `done` pulse is produced.

## Timing
- **Reset values:** `m_read`, `m_write`, `busy`, `done`, `pass` and `timeout` are 0. `m_address` = 0, `m_writedata` = 0, `err_count` = 0, `first_err_addr` = 0. `m_burstcount` = `BURST`, `m_byteenable` = 2'b11.
- All outputs are registered.
- `start` to first `m_write` high: 1 cycle.
- Write request behaviour:
  - The slave holds `m_waitrequest` high until it is ready, which can take hundreds of cycles after power-up initialisation.
  - The master holds `m_address` and `m_writedata` stable while stalled.
- Back-to-back accepted write beats advance `m_address` and `m_writedata` on consecutive cycles.
- The compare result is registered 1 cycle after `m_readdatavalid`.
- `done` asserts 1 cycle after the last read beat's compare. `err_count` is final in that same cycle.
- Minimum test length, zero-wait slave: about `NUM_BURSTS`*(2*`BURST`+3) cycles plus slave latency.

## Test plan
- **Ideal slave model:** behavioural SDRAM model behind the controller, `BURST`=8, `NUM_BURSTS`=4, `BASE_ADDR`=0. Pulse `start` → 32 write beats with data pat(0..31) (first beat 16'hA5A5), then 4 read bursts → `done` pulse, `pass`=1, `err_count`=0, `first_err_addr`=0.
- **Stuck bit:** model forces bit 3 of the word at address 5 → `err_count`=1, `first_err_addr`=22'h000005, `pass`=0.
- **Wait-state stalls:** random `m_waitrequest` stalls (0–20 cycles) → no beat duplicated or skipped; each address is written exactly once with pat(addr); `pass`=1.
- **Address wrap:** `BASE_ADDR`=22'h3FFFFC, `BURST`=4, `NUM_BURSTS`=2 → second burst addresses are 0..3; pattern is correct; `pass`=1.
- **Timeout:** slave never returns `m_readdatavalid`, `TIMEOUT`=64 → `timeout`=1, `pass`=0, `done` pulses, all requests are low.
- **Reset and start handling:** assert `reset` mid write pass → `m_write`=0 immediately, `busy`=0, no `done`. A new `start` then runs normally. A second `start` while `busy` has no effect.
